axi_stream_keep_packer: RTL and testbench

- Sits directly downstream of the AXI-Stream header inserter. Consumes the header-inserted stream, where the header beat carries only some valid bytes (partial keep).
- Removes null byte positions so the output packet is byte-contiguous.
- Every output beat is full (keep all ones) except the final beat of a packet, which is MSB-aligned.
- Byte order: lane DATA_BYTE_WD-1 (MSB) is first on the wire.

---
 rtl/axis_pkg.sv | 13 +
 rtl/axis_byte_compactor.sv | 23 ++
 rtl/axi_stream_keep_packer.sv | 84 ++++++++
 tb/tb_axi_stream_keep_packer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// axis_pkg: shared stream types and byte-lane helpers (popcount, MSB-aligned keep, packer state)
package axis_pkg;
  localparam int MAX_W = 64;
  typedef enum logic {RUN, FLUSH} state_t;
  function automatic int popcount(input logic [MAX_W-1:0] keep);
    popcount = 0;
    for (int i = 0; i < MAX_W; i++) popcount += int'(keep[i]);
  endfunction
  function automatic logic [MAX_W-1:0] msb_keep(input int cnt, input int w);
    msb_keep = '0;
    for (int i = 0; i < MAX_W; i++) if (i < w && i >= w - cnt) msb_keep[i] = 1'b1;
  endfunction
endpackage

// File: rtl/axis_byte_compactor.sv
// axis_byte_compactor: packs keep-enabled bytes of data (MSB lane first) into aligned, left-justified, with their count
module axis_byte_compactor import axis_pkg::*; #(
  parameter int W = 4,
  parameter int CNT_WD = $clog2(W) + 1
) (
  input  logic [8*W-1:0]    data,
  input  logic [W-1:0]      keep,
  output logic [8*W-1:0]    aligned,
  output logic [CNT_WD-1:0] count
);
  assign count = CNT_WD'(popcount(MAX_W'(keep)));
  always_comb begin
    int n;
    aligned = '0;
    n = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (keep[i]) begin
        aligned[8*(W-1-n) +: 8] = data[8*i +: 8];
        n++;
      end
    end
  end
endmodule

// File: rtl/axi_stream_keep_packer.sv
// axi_stream_keep_packer: removes null bytes (clk, rst_n; valid/data/keep/last/ready in and out) so every beat is full except an MSB-aligned last
module axi_stream_keep_packer import axis_pkg::*; #(
  parameter int DATA_WD = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int CNT_WD = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);
  localparam logic [CNT_WD-1:0] WC = CNT_WD'(DATA_BYTE_WD);
  logic [DATA_WD-1:0] cdata, res;
  logic [CNT_WD-1:0] ccnt, rcnt, total;
  logic [2*DATA_WD-1:0] cat;
  logic [MAX_W-1:0] keep_total, keep_res;
  logic out_free, accept;
  state_t state;
  axis_byte_compactor #(.W(DATA_BYTE_WD), .CNT_WD(CNT_WD)) u_compactor (
    .data(data_in),
    .keep(keep_in),
    .aligned(cdata),
    .count(ccnt)
  );
  assign out_free = !valid_out || ready_out;
  assign ready_in = rst_n && state == RUN && out_free;
  assign accept = valid_in && ready_in;
  assign total = rcnt + ccnt;
  assign cat = {res, {DATA_WD{1'b0}}} | ({cdata, {DATA_WD{1'b0}}} >> {rcnt, 3'b000});
  assign keep_total = msb_keep(int'(total), DATA_BYTE_WD);
  assign keep_res = msb_keep(int'(rcnt), DATA_BYTE_WD);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      rcnt <= '0;
      res <= '0;
      valid_out <= 1'b0;
      data_out <= '0;
      keep_out <= '0;
      last_out <= 1'b0;
    end else if (state == FLUSH) begin
      if (out_free) begin
        valid_out <= 1'b1;
        data_out <= res;
        keep_out <= keep_res[DATA_BYTE_WD-1:0];
        last_out <= 1'b1;
        rcnt <= '0;
        res <= '0;
        state <= RUN;
      end
    end else if (accept) begin
      if (last_in && total <= WC) begin
        valid_out <= 1'b1;
        data_out <= cat[2*DATA_WD-1:DATA_WD];
        keep_out <= keep_total[DATA_BYTE_WD-1:0];
        last_out <= 1'b1;
        rcnt <= '0;
        res <= '0;
      end else if (total >= WC) begin
        valid_out <= 1'b1;
        data_out <= cat[2*DATA_WD-1:DATA_WD];
        keep_out <= '1;
        last_out <= 1'b0;
        rcnt <= total - WC;
        res <= cat[DATA_WD-1:0];
        state <= last_in ? FLUSH : RUN;
      end else begin
        valid_out <= 1'b0;
        rcnt <= total;
        res <= cat[2*DATA_WD-1:DATA_WD];
      end
    end else if (out_free) begin
      valid_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_stream_keep_packer.sv
// tb_axi_stream_keep_packer: byte-queue reference model plus directed literal beats and randomized traffic
module tb_axi_stream_keep_packer;
  localparam int DW = 32;
  localparam int W = 4;
  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic last_in = 1'b0;
  logic ready_out = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [W-1:0] keep_in = '0;
  logic ready_in, valid_out, last_out;
  logic [DW-1:0] data_out;
  logic [W-1:0] keep_out;
  beat_t exp_q[$];
  beat_t got[$];
  logic [7:0] bq[$];
  int n_chk = 0;
  int n_fail = 0;
  logic hold = 1'b0;
  logic rdy_seen = 1'b0;
  logic [37:0] held = '0;
  always #5 clk = ~clk;
  axi_stream_keep_packer #(.DATA_WD(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .valid_in(valid_in),
    .data_in(data_in),
    .keep_in(keep_in),
    .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out),
    .data_out(data_out),
    .keep_out(keep_out),
    .last_out(last_out),
    .ready_out(ready_out)
  );
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  task automatic emit(input int n, input logic l);
    beat_t b;
    b.d = '0;
    b.k = '0;
    b.l = l;
    for (int i = 0; i < n; i++) begin
      b.d[8*(W-1-i) +: 8] = bq.pop_front();
      b.k[W-1-i] = 1'b1;
    end
    exp_q.push_back(b);
  endtask
  task automatic model_accept(input logic [31:0] d, input logic [3:0] k, input logic l);
    for (int i = W - 1; i >= 0; i--) if (k[i]) bq.push_back(d[8*i +: 8]);
    if (l) begin
      while (bq.size() > W) emit(W, 1'b0);
      emit(bq.size(), 1'b1);
    end else begin
      while (bq.size() >= W) emit(W, 1'b0);
    end
  endtask
  task automatic step(input logic v, input logic [31:0] d, input logic [3:0] k, input logic l,
                      input logic r, output logic acc);
    beat_t b;
    beat_t e;
    @(negedge clk);
    valid_in = v;
    data_in = d;
    keep_in = k;
    last_in = l;
    ready_out = r;
    #1;
    rdy_seen = ready_in;
    if (hold) chk("hold", {26'd0, valid_out, data_out, keep_out, last_out}, {26'd0, held});
    if (valid_out && !ready_out) chk("rdy_bp", 64'(ready_in), 64'd0);
    acc = v && ready_in;
    if (valid_out && ready_out) begin
      b.d = data_out;
      b.k = keep_out;
      b.l = last_out;
      got.push_back(b);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL out: unexpected beat data %h keep %b last %b", data_out, keep_out, last_out);
      end else begin
        e = exp_q.pop_front();
        chk("out", {27'd0, data_out, keep_out, last_out}, {27'd0, e.d, e.k, e.l});
      end
    end
    hold = valid_out && !ready_out;
    held = {valid_out, data_out, keep_out, last_out};
    if (acc) model_accept(d, k, l);
  endtask
  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) step(1'b1, d, k, l, 1'b1, acc);
    chk("send_timeout", 64'(acc), 64'd1);
  endtask
  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 4'd0, 1'b0, 1'b1, acc);
  endtask
  task automatic exp_beat(input string nm, input int i, input logic [31:0] d, input logic [3:0] k, input logic l);
    if (i >= got.size()) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: beat %0d missing, got %0d beats", nm, i, got.size());
    end else begin
      chk(nm, {27'd0, got[i].d, got[i].k, got[i].l}, {27'd0, d, k, l});
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid_in = 1'b0;
    ready_out = 1'b0;
    #1;
    chk("rst_ready_in", 64'(ready_in), 64'd0);
    @(negedge clk);
    #1;
    chk("rst_outputs", {27'd0, valid_out, data_out, keep_out, last_out}, 64'd0);
    bq.delete();
    exp_q.delete();
    got.delete();
    hold = 1'b0;
    rst_n = 1'b1;
  endtask
  initial begin
    logic acc;
    logic v, l;
    logic [31:0] d;
    logic [3:0] k;
    do_reset();
    idle(2);
    got.delete();
    send(32'h0000AABB, 4'b0011, 1'b0);
    send(32'h11223344, 4'hF, 1'b0);
    send(32'h55667788, 4'b1100, 1'b1);
    idle(4);
    chk("t1_count", 64'(got.size()), 64'd2);
    exp_beat("t1_b0", 0, 32'hAABB1122, 4'hF, 1'b0);
    exp_beat("t1_b1", 1, 32'h33445566, 4'hF, 1'b1);
    got.delete();
    send(32'h00AABBCC, 4'b0111, 1'b0);
    send(32'h11223344, 4'hF, 1'b1);
    step(1'b0, 32'd0, 4'd0, 1'b0, 1'b1, acc);
    chk("t2_flush_rdy", 64'(rdy_seen), 64'd0);
    step(1'b0, 32'd0, 4'd0, 1'b0, 1'b1, acc);
    chk("t2_run_rdy", 64'(rdy_seen), 64'd1);
    idle(3);
    exp_beat("t2_b0", 0, 32'hAABBCC11, 4'hF, 1'b0);
    exp_beat("t2_b1", 1, 32'h22334400, 4'b1110, 1'b1);
    got.delete();
    send(32'h01020304, 4'hF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h05060708, 4'hF, 1'b1, 1'b0, acc);
      chk("t3_bp_valid", 64'(valid_out), 64'd1);
    end
    send(32'h05060708, 4'hF, 1'b1);
    idle(4);
    chk("t3_count", 64'(got.size()), 64'd2);
    exp_beat("t3_b0", 0, 32'h01020304, 4'hF, 1'b0);
    exp_beat("t3_b1", 1, 32'h05060708, 4'hF, 1'b1);
    got.delete();
    send(32'h12345678, 4'b0000, 1'b1);
    idle(3);
    exp_beat("t4_null", 0, 32'h00000000, 4'b0000, 1'b1);
    got.delete();
    send(32'h0000AABB, 4'b0011, 1'b0);
    send(32'h99999999, 4'b0000, 1'b1);
    idle(3);
    exp_beat("t4_rcnt2", 0, 32'hAABB0000, 4'b1100, 1'b1);
    got.delete();
    send(32'h11223344, 4'b1010, 1'b0);
    send(32'h55667788, 4'b0101, 1'b1);
    idle(3);
    exp_beat("t5_sparse", 0, 32'h11336688, 4'hF, 1'b1);
    got.delete();
    send(32'h00AABBCC, 4'b0111, 1'b0);
    send(32'h11223344, 4'hF, 1'b0);
    step(1'b0, 32'd0, 4'd0, 1'b0, 1'b0, acc);
    chk("t6_pre_valid", 64'(valid_out), 64'd1);
    do_reset();
    send(32'hDEADBEEF, 4'hF, 1'b1);
    idle(3);
    chk("t6_count", 64'(got.size()), 64'd1);
    exp_beat("t6_after", 0, 32'hDEADBEEF, 4'hF, 1'b1);
    acc = 1'b0;
    v = 1'b0;
    d = '0;
    k = '0;
    l = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (!v || acc) begin
        v = ($urandom % 5) != 0;
        d = $urandom;
        k = 4'($urandom);
        l = ($urandom % 4) == 0;
      end
      step(v, d, k, l, ($urandom % 10) < 7, acc);
    end
    idle(10);
    chk("drain", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
